// File: rtl/ram_arbiter.sv
// Two-port arbiter and access sequencer in front of a single-port synchronous RAM.
// Tie-break: RAM_ARB_RR_EN defined -> round-robin; undefined -> fixed priority, port A wins.
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  // state | meaning
  // IDLE  | no access in flight; arbitrate and latch the winner
  // WR    | RAM write cycle (ena=1, wena=1)
  // RD    | RAM read cycle (ena=1, wena=0)
  // CAP   | RAM output valid; capture into rdata
  // DONE  | access complete; owner's ack is registered out next cycle
  typedef enum logic [2:0] {IDLE, WR, RD, CAP, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_we;
  logic              r_ack_a;
  logic              r_ack_b;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_grant;
  logic              w_win;
  logic              w_win_we;

`ifdef RAM_ARB_RR_EN
  logic r_last;

  always_comb begin
    w_win = req_b;
    if (req_a && req_b) w_win = ~r_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_last <= 1'b1;
    else if (r_state == DONE)  r_last <= r_owner;
  end
`else
  always_comb begin
    w_win = ~req_a;
  end
`endif

  // The ack cycle is spent in IDLE with the owner's req still high; do not treat it as a new request.
  assign w_grant  = (r_state == IDLE) && (req_a || req_b) && !(r_ack_a || r_ack_b);
  assign w_win_we = w_win ? we_b : we_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = w_win_we ? WR : RD;
      WR:      w_next = DONE;
      RD:      w_next = CAP;
      CAP:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
    end else begin
      r_ack_a <= (r_state == DONE) && !r_owner;
      r_ack_b <= (r_state == DONE) && r_owner;
      if (w_grant) begin
        r_owner <= w_win;
        r_we    <= w_win_we;
        r_addr  <= w_win ? addr_b  : addr_a;
        r_wdata <= w_win ? wdata_b : wdata_a;
      end
      if (r_state == CAP) r_rdata <= ram_dout;
    end
  end

  assign ram_ena  = (r_state == WR) || (r_state == RD);
  assign ram_wena = (r_state == WR) && r_we;
  assign ram_addr = r_addr;
  assign ram_din  = r_wdata;
  assign busy     = (r_state != IDLE);
  assign ack_a    = r_ack_a;
  assign ack_b    = r_ack_b;
  assign rdata    = r_rdata;

endmodule
